inst_prefetch_queue: RTL and testbench

Instruction prefetch stage between the synchronous instruction ROM and the control decoder/register-file stage. It issues sequential 9-bit instruction fetches into a small queue, tagging each instruction with its program counter. It hands instructions downstream with a valid/ready handshake. On branch or jump redirects it flushes the queue and restarts fetching at the new target. It stops fetching after the halt instruction (all ones) and flags completion when that instruction is consumed.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/inst_queue.sv | 53 +++++
 rtl/inst_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction prefetch stage
package fetch_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_IW = 9;

    // The halt instruction is the all-ones word.
    localparam logic [DEF_IW-1:0] HALT_INST = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetchState_e;

    typedef struct packed {
        logic [DEF_IW-1:0] inst;
        logic [DEF_AW-1:0] pc;
    } entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - small synchronous FIFO of fetched instruction entries
module inst_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Flush,
    input  logic                    Push,
    input  T                        PushData,
    input  logic                    Pop,
    output logic [$clog2(DEPTH):0]  Count,
    output T                        Head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PtrOne = 1;
    localparam logic [PW:0]   CntOne = 1;

    T              mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    // Storage and pointers; flush drops every entry, push and pop may coincide.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else if (Flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (Push) begin
                mem[wrPtr] <= PushData;
                wrPtr      <= wrPtr + PtrOne;
            end
            if (Pop) rdPtr <= rdPtr + PtrOne;
            case ({Push, Pop})
                2'b10:   Count <= Count + CntOne;
                2'b01:   Count <= Count - CntOne;
                default: Count <= Count;
            endcase
        end
    end

    assign Head = mem[rdPtr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - sequential instruction prefetch with flush on redirect (PREFETCH_BYPASS_EN adds an empty-queue bypass)
module inst_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEF_AW,
    parameter int IW    = DEF_IW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Redirect,
    input  logic [AW-1:0] RedirectPc,
    output logic          MemReq,
    output logic [AW-1:0] MemAddr,
    input  logic [IW-1:0] MemData,
    output logic          InstValid,
    output logic [IW-1:0] Inst,
    output logic [AW-1:0] InstPc,
    input  logic          InstReady,
    output logic          Halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] HaltWord = {IW{HALT_INST[0]}};
    localparam logic [AW-1:0] PcOne    = 1;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
    } qEntry_t;

    fetchState_e   state;
    fetchState_e   stateNext;
    logic [AW-1:0] fetchPc;
    logic [AW-1:0] pendPc;
    logic          pending;
    logic [CW-1:0] count;
    logic [CW:0]   inFlight;
    qEntry_t       head;
    qEntry_t       pushData;
    logic          flush;
    logic          live;
    logic          respHalt;
    logic          reqOk;
    logic          push;
    logic          pop;
    logic          deq;

    // A response is only kept when no restart lands in the cycle it returns.
    assign flush    = Start | Redirect;
    assign live     = pending & ~flush;
    assign respHalt = live && (MemData == HaltWord);
    assign inFlight = {1'b0, count} + {{CW{1'b0}}, pending};
    assign reqOk    = inFlight < (CW+1)'(DEPTH);
    assign pushData = {MemData, pendPc};
    assign MemAddr  = fetchPc;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = live && (count == '0);
    assign InstValid = bypass || (count != '0);
    assign Inst      = bypass ? MemData : head.inst;
    assign InstPc    = bypass ? pendPc  : head.pc;
    assign push      = live && !(bypass && InstReady);
    assign pop       = InstValid && InstReady && !bypass;
`else
    assign InstValid = count != '0;
    assign Inst      = head.inst;
    assign InstPc    = head.pc;
    assign push      = live;
    assign pop       = InstValid && InstReady;
`endif

    assign deq = InstValid && InstReady;

    inst_queue #(
        .DEPTH (DEPTH),
        .T     (qEntry_t)
    ) u_queue (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Flush    (flush),
        .Push     (push),
        .PushData (pushData),
        .Pop      (pop),
        .Count    (count),
        .Head     (head)
    );

    // Fetch state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Next state and request issue; the halt response suppresses the request beside it.
    always_comb begin
        stateNext = state;
        MemReq    = 1'b0;
        if (Start) begin
            stateNext = FETCH;
        end else begin
            case (state)
                IDLE:    stateNext = IDLE;
                FETCH:   if (respHalt) stateNext = HALT;
                HALT:    if (Redirect) stateNext = FETCH;
                default: stateNext = IDLE;
            endcase
        end
        MemReq = (state == FETCH) && reqOk && !flush && !respHalt;
    end

    // Fetch PC, in-flight request tracking and the sticky halt flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fetchPc <= '0;
            pendPc  <= '0;
            pending <= 1'b0;
            Halted  <= 1'b0;
        end else begin
            pending <= MemReq;
            if (MemReq) pendPc <= fetchPc;
            if (Start)         fetchPc <= '0;
            else if (Redirect) fetchPc <= RedirectPc;
            else if (MemReq)   fetchPc <= fetchPc + PcOne;
            if (Start)                          Halted <= 1'b0;
            else if (deq && (Inst == HaltWord)) Halted <= 1'b1;
        end
    end

    // The credit rule keeps a live response from ever finding the queue full.
    assert property (@(posedge Clk) disable iff (!Reset_n) !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - self-checking bench for inst_prefetch_queue (define PREFETCH_BYPASS_EN for the bypass build)
module tb_inst_prefetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int IW    = 9;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Redirect = 1'b0;
    logic [AW-1:0] RedirectPc = '0;
    logic          MemReq;
    logic [AW-1:0] MemAddr;
    logic [IW-1:0] MemData = '0;
    logic          InstValid;
    logic [IW-1:0] Inst;
    logic [AW-1:0] InstPc;
    logic          InstReady = 1'b0;
    logic          Halted;

    logic [IW-1:0] rom [1<<AW];
    int nCmp = 0;
    int nErr = 0;

    inst_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Redirect(Redirect),
        .RedirectPc(RedirectPc), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemData(MemData), .InstValid(InstValid), .Inst(Inst), .InstPc(InstPc),
        .InstReady(InstReady), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: data the cycle after the request.
    always @(posedge Clk) if (MemReq) MemData <= rom[MemAddr];

    task automatic fillRom();
        for (int i = 0; i < (1<<AW); i++) rom[i] = IW'($urandom_range(0, 510));
    endtask

    task automatic doReset();
        @(negedge Clk);
        Reset_n = 1'b0; Start = 1'b0; Redirect = 1'b0; InstReady = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset_n = 1'b0; Start = 1'b0; Redirect = 1'b0; InstReady = 1'b0;
        #1;
        nCmp++; if (MemReq !== 1'b0)    begin nErr++; $display("FAIL reset_memreq got %b want 0", MemReq); end
        nCmp++; if (MemAddr !== '0)     begin nErr++; $display("FAIL reset_memaddr got %h want 0", MemAddr); end
        nCmp++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL reset_valid got %b want 0", InstValid); end
        nCmp++; if (Inst !== '0)        begin nErr++; $display("FAIL reset_inst got %h want 0", Inst); end
        nCmp++; if (InstPc !== '0)      begin nErr++; $display("FAIL reset_pc got %h want 0", InstPc); end
        nCmp++; if (Halted !== 1'b0)    begin nErr++; $display("FAIL reset_halted got %b want 0", Halted); end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk); #1;
            nCmp++; if (MemReq !== 1'b0 || InstValid !== 1'b0)
                begin nErr++; $display("FAIL idle_quiet req=%b valid=%b want 0/0", MemReq, InstValid); end
        end
    endtask

    task automatic test_start_halt();
        logic [IW-1:0] prog [4];
        int nReq;
        logic expValid;
        logic expReq;
        prog[0] = 9'h001; prog[1] = 9'h002; prog[2] = 9'h003; prog[3] = HALT_INST;
        doReset();
        for (int i = 0; i < 4; i++) rom[i] = prog[i];
        nReq = 0;
        InstReady = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            expValid = (c >= LAT) && (c < LAT + 4);
            expReq   = (c <= 4);
            nCmp++; if (InstValid !== expValid) begin nErr++; $display("FAIL sh_valid c=%0d got %b want %b", c, InstValid, expValid); end
            if (expValid) begin
                nCmp++; if (Inst !== prog[c-LAT])    begin nErr++; $display("FAIL sh_inst c=%0d got %h want %h", c, Inst, prog[c-LAT]); end
                nCmp++; if (InstPc !== AW'(c-LAT))   begin nErr++; $display("FAIL sh_pc c=%0d got %h want %h", c, InstPc, AW'(c-LAT)); end
            end
            nCmp++; if (Halted !== (c >= LAT + 4)) begin nErr++; $display("FAIL sh_halted c=%0d got %b want %b", c, Halted, (c >= LAT + 4)); end
            nCmp++; if (MemReq !== expReq) begin nErr++; $display("FAIL sh_memreq c=%0d got %b want %b", c, MemReq, expReq); end
            if (expReq) begin
                nCmp++; if (MemAddr !== AW'(c-1)) begin nErr++; $display("FAIL sh_memaddr c=%0d got %h want %h", c, MemAddr, AW'(c-1)); end
            end
            if (MemReq) nReq++;
            @(negedge Clk);
        end
        nCmp++; if (nReq != 4) begin nErr++; $display("FAIL sh_reqcount got %0d want 4", nReq); end
    endtask

    task automatic test_backpressure();
        int nReq;
        int got;
        int firstAddr;
        logic [AW-1:0] expPc;
        doReset();
        for (int i = 0; i < 64; i++) rom[i] = 9'h040 + IW'(i);
        nReq = 0;
        InstReady = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (MemReq) nReq++;
            @(negedge Clk);
        end
        #1;
        nCmp++; if (nReq != DEPTH)      begin nErr++; $display("FAIL bp_reqcount got %0d want %0d", nReq, DEPTH); end
        nCmp++; if (MemReq !== 1'b0)    begin nErr++; $display("FAIL bp_memreq_full got %b want 0", MemReq); end
        nCmp++; if (InstValid !== 1'b1) begin nErr++; $display("FAIL bp_valid got %b want 1", InstValid); end
        nCmp++; if (Inst !== rom[0] || InstPc !== '0)
            begin nErr++; $display("FAIL bp_head got %h@%h want %h@000", Inst, InstPc, rom[0]); end
        @(negedge Clk);
        InstReady = 1'b1;
        got = 0; firstAddr = -1; expPc = '0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            #1;
            if (MemReq && firstAddr < 0) firstAddr = int'(MemAddr);
            if (InstValid) begin
                nCmp++; if (Inst !== rom[expPc] || InstPc !== expPc)
                    begin nErr++; $display("FAIL bp_order got %h@%h want %h@%h", Inst, InstPc, rom[expPc], expPc); end
                expPc = expPc + 1'b1;
                got++;
            end
            @(negedge Clk);
        end
        nCmp++; if (got != 10)      begin nErr++; $display("FAIL bp_drain got %0d want 10", got); end
        nCmp++; if (firstAddr != 4) begin nErr++; $display("FAIL bp_resume_addr got %0d want 4", firstAddr); end
        InstReady = 1'b0;
    endtask

    task automatic test_redirect();
        int firstD;
        int got;
        logic [AW-1:0] expPc;
        doReset();
        for (int i = 0; i < 16; i++) rom[10'h2F0 + i] = 9'h100 + IW'(i);
        InstReady = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Redirect = 1'b1; RedirectPc = 10'h2F0;
        #1;
        nCmp++; if (InstValid !== 1'b1 || Inst !== rom[0])
            begin nErr++; $display("FAIL rd_prequeue got %b/%h want 1/%h", InstValid, Inst, rom[0]); end
        @(negedge Clk);
        Redirect = 1'b0; InstReady = 1'b1;
        firstD = 0; got = 0; expPc = 10'h2F0;
        for (int d = 1; d <= 12; d++) begin
            #1;
            if (d == 1) begin
                nCmp++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL rd_flushed got %b want 0", InstValid); end
                nCmp++; if (MemReq !== 1'b1 || MemAddr !== 10'h2F0)
                    begin nErr++; $display("FAIL rd_req got %b@%h want 1@2f0", MemReq, MemAddr); end
            end
            if (InstValid && got < 3) begin
                if (firstD == 0) firstD = d;
                nCmp++; if (Inst !== rom[expPc] || InstPc !== expPc)
                    begin nErr++; $display("FAIL rd_seq got %h@%h want %h@%h", Inst, InstPc, rom[expPc], expPc); end
                expPc = expPc + 1'b1;
                got++;
            end
            @(negedge Clk);
        end
        nCmp++; if (firstD != LAT) begin nErr++; $display("FAIL rd_latency got %0d want %0d", firstD, LAT); end
        nCmp++; if (got != 3)      begin nErr++; $display("FAIL rd_count got %0d want 3", got); end
    endtask

    task automatic test_wrap();
        int got;
        logic [AW-1:0] expPc;
        doReset();
        InstReady = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        Redirect = 1'b1; RedirectPc = 10'h3FF;
        @(negedge Clk);
        Redirect = 1'b0; InstReady = 1'b1;
        got = 0; expPc = 10'h3FF;
        for (int c = 0; c < 12 && got < 3; c++) begin
            #1;
            if (InstValid) begin
                nCmp++; if (Inst !== rom[expPc] || InstPc !== expPc)
                    begin nErr++; $display("FAIL wrap_seq got %h@%h want %h@%h", Inst, InstPc, rom[expPc], expPc); end
                expPc = expPc + 1'b1;
                got++;
            end
            @(negedge Clk);
        end
        nCmp++; if (got != 3) begin nErr++; $display("FAIL wrap_count got %0d want 3", got); end
    endtask

    task automatic test_start_redirect();
        int got;
        doReset();
        InstReady = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(negedge Clk);
        Start = 1'b1; Redirect = 1'b1; RedirectPc = 10'h155;
        @(negedge Clk);
        Start = 1'b0; Redirect = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #1;
            if (InstValid) begin
                got = 1;
                nCmp++; if (InstPc !== '0 || Inst !== rom[0])
                    begin nErr++; $display("FAIL sr_restart got %h@%h want %h@000", Inst, InstPc, rom[0]); end
            end
            @(negedge Clk);
        end
        nCmp++; if (got != 1) begin nErr++; $display("FAIL sr_timeout got %0d want 1", got); end
        repeat (3) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        nCmp++; if ({MemReq, MemAddr, InstValid, Inst, InstPc, Halted} !== '0)
            begin nErr++; $display("FAIL sr_async_reset got req=%b addr=%h v=%b i=%h pc=%h h=%b want all 0",
                                   MemReq, MemAddr, InstValid, Inst, InstPc, Halted); end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk); #1;
            nCmp++; if (MemReq !== 1'b0 || InstValid !== 1'b0)
                begin nErr++; $display("FAIL sr_idle req=%b valid=%b want 0/0", MemReq, InstValid); end
        end
        InstReady = 1'b0;
    endtask

    task automatic test_random();
        logic [AW-1:0] expPc;
        logic          expHalted;
        logic          stopped;
        logic          prevHold;
        logic [IW-1:0] prevInst;
        logic [AW-1:0] prevPc;
        logic          isHalt;
        logic          deq;
        int            nDeq;
        doReset();
        fillRom();
        for (int k = 0; k < 8; k++) rom[$urandom_range(0, (1<<AW)-1)] = HALT_INST;
        expPc = '0; expHalted = 1'b0; stopped = 1'b1; prevHold = 1'b0;
        prevInst = '0; prevPc = '0; nDeq = 0;
        for (int i = 0; i < 800; i++) begin
            InstReady  = ($urandom_range(0, 3) != 0);
            Redirect   = stopped ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            RedirectPc = AW'($urandom);
            Start      = (i == 0) || ($urandom_range(0, 99) == 0);
            #1;
            if (prevHold) begin
                nCmp++; if (Inst !== prevInst || InstPc !== prevPc)
                    begin nErr++; $display("FAIL rnd_stable i=%0d got %h@%h want %h@%h", i, Inst, InstPc, prevInst, prevPc); end
            end
            if (stopped) begin
                nCmp++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL rnd_stopped i=%0d got %b want 0", i, InstValid); end
            end
            nCmp++; if (Halted !== expHalted) begin nErr++; $display("FAIL rnd_halted i=%0d got %b want %b", i, Halted, expHalted); end
            deq = InstValid && InstReady;
            isHalt = 1'b0;
            if (deq) begin
                nCmp++; if (Inst !== rom[expPc] || InstPc !== expPc)
                    begin nErr++; $display("FAIL rnd_inst i=%0d got %h@%h want %h@%h", i, Inst, InstPc, rom[expPc], expPc); end
                isHalt = (rom[expPc] == HALT_INST);
                expPc = expPc + 1'b1;
                nDeq++;
            end
            prevHold = InstValid && !InstReady && !Start && !Redirect;
            prevInst = Inst;
            prevPc   = InstPc;
            if (Start) begin
                expPc = '0; expHalted = 1'b0; stopped = 1'b0;
            end else begin
                if (deq && isHalt) begin expHalted = 1'b1; stopped = 1'b1; end
                if (Redirect) begin expPc = RedirectPc; stopped = 1'b0; end
            end
            @(negedge Clk);
        end
        Start = 1'b0; Redirect = 1'b0; InstReady = 1'b0;
        nCmp++; if (nDeq < 50) begin nErr++; $display("FAIL rnd_progress got %0d want >=50", nDeq); end
    endtask

    initial begin
        fillRom();
        test_reset();
        test_start_halt();
        fillRom();
        test_backpressure();
        fillRom();
        test_redirect();
        fillRom();
        test_wrap();
        fillRom();
        test_start_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
